// File: rtl/mul_pipe.sv
// Pipelined integer multiplier (u*u, s*s, s*u) with tag side-band, global stall and flush.
// Define MUL_PIPE_ACC_EN to add the in_acc/in_acc_op multiply-accumulate ports.
module mul_pipe #(
   parameter int WIDTH = 32,
   parameter int SPLIT = 16,
   parameter int TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef MUL_PIPE_ACC_EN
   input  logic [2*WIDTH-1:0] in_acc,
   input  logic [1:0]         in_acc_op,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_result,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int NCH = WIDTH / SPLIT;
   localparam int NPP = NCH * NCH;
   localparam int PW  = 2 * WIDTH;

   // s0 is the accept register; s1..s3 are the sign/magnitude, sub-product and sum stages.
   logic                      s0_valid_q, s1_valid_q, s2_valid_q, s3_valid_q;
   logic [WIDTH-1:0]          s0_a_q, s0_b_q;
   logic [1:0]                s0_mode_q;
   logic [TAG_W-1:0]          s0_tag_q, s1_tag_q, s2_tag_q, s3_tag_q;
   logic [WIDTH-1:0]          s1_a_q, s1_b_q, s1_a_d, s1_b_d;
   logic                      s1_neg_q, s1_neg_d, s2_neg_q;
   logic [NPP-1:0][2*SPLIT-1:0] s2_pp_q, s2_pp_d;
   logic [PW-1:0]             s3_result_q, s3_result_d, sum;
   logic                      a_sgn, b_sgn, stall;
`ifdef MUL_PIPE_ACC_EN
   logic [PW-1:0]             s0_acc_q, s1_acc_q, s2_acc_q;
   logic [1:0]                s0_aop_q, s1_aop_q, s2_aop_q;
`endif

   assign stall      = s3_valid_q & ~out_ready;
   assign in_ready   = ~stall;
   assign out_valid  = s3_valid_q;
   assign out_result = s3_result_q;
   assign out_tag    = s3_tag_q;
   assign busy       = s0_valid_q | s1_valid_q | s2_valid_q | s3_valid_q;

   always_comb begin
      a_sgn    = s0_a_q[WIDTH-1] & ((s0_mode_q == 2'b01) || (s0_mode_q == 2'b10));
      b_sgn    = s0_b_q[WIDTH-1] & (s0_mode_q == 2'b01);
      s1_a_d   = a_sgn ? -s0_a_q : s0_a_q;
      s1_b_d   = b_sgn ? -s0_b_q : s0_b_q;
      s1_neg_d = a_sgn ^ b_sgn;
   end

   always_comb begin
      s2_pp_d = '0;
      for (int i = 0; i < NCH; i++) begin
         for (int j = 0; j < NCH; j++) begin
            s2_pp_d[i*NCH+j] = {{SPLIT{1'b0}}, s1_a_q[i*SPLIT +: SPLIT]} *
                               {{SPLIT{1'b0}}, s1_b_q[j*SPLIT +: SPLIT]};
         end
      end
   end

   // Carries out of the top bit are dropped; the product always fits in PW bits.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NCH; i++) begin
         for (int j = 0; j < NCH; j++) begin
            sum = sum + (PW'(s2_pp_q[i*NCH+j]) << (SPLIT * (i + j)));
         end
      end
      s3_result_d = s2_neg_q ? -sum : sum;
`ifdef MUL_PIPE_ACC_EN
      case (s2_aop_q)
         2'b01:   s3_result_d = s3_result_d + s2_acc_q;
         2'b10:   s3_result_d = s3_result_d - s2_acc_q;
         default: s3_result_d = s3_result_d;
      endcase
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s0_valid_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s3_valid_q  <= 1'b0;
         s3_result_q <= '0;
         s3_tag_q    <= '0;
      end else begin
         if (flush) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
         end else if (!stall) begin
            s0_valid_q <= in_valid;
            s1_valid_q <= s0_valid_q;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
         end
         // Output data only moves for real operations so it stays quiet between results.
         if (!stall && s2_valid_q) begin
            s3_result_q <= s3_result_d;
            s3_tag_q    <= s2_tag_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         s0_a_q    <= in_a;
         s0_b_q    <= in_b;
         s0_mode_q <= in_mode;
         s0_tag_q  <= in_tag;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_neg_q  <= s1_neg_d;
         s1_tag_q  <= s0_tag_q;
         s2_pp_q   <= s2_pp_d;
         s2_neg_q  <= s1_neg_q;
         s2_tag_q  <= s1_tag_q;
`ifdef MUL_PIPE_ACC_EN
         s0_acc_q  <= in_acc;
         s0_aop_q  <= in_acc_op;
         s1_acc_q  <= s0_acc_q;
         s1_aop_q  <= s0_aop_q;
         s2_acc_q  <= s1_acc_q;
         s2_aop_q  <= s1_aop_q;
`endif
      end
   end

endmodule
